// File: rtl/pc_sequencer_if.sv
// Instruction-fetch bus between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_inst;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/retire controller: owns the architectural PC, sequences
// fetch request, fetch response and execute, and flags halt / misaligned-target traps.
module pc_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.master     ifu,
  output logic [31:0]        inst,
  output logic               inst_valid,
  input  logic               exec_done,
  input  logic               pc_a_src,
  input  logic               pc_b_src,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    rs1,
  input  logic               halt_req,
  output logic [XLEN-1:0]    pc,
  output logic               halted,
  output logic               misalign_err,
  output logic [63:0]        instret
);

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StExec,
    StHalt,
    StTrap
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] next_pc;

  // Register-relative targets (jalr-style) drop bit 0 of the sum.
  always_comb begin
    add_a   = pc_a_src ? imm : XLEN'(4);
    add_b   = pc_b_src ? rs1 : pc_q;
    sum     = add_a + add_b;
    next_pc = pc_b_src ? {sum[XLEN-1:1], 1'b0} : sum;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    unique case (state_q)
      StFetch: begin
        if (ifu.ifu_req_ready) state_d = StWait;
      end
      StWait: begin
        if (ifu.ifu_rsp_valid) begin
          inst_d  = ifu.ifu_rsp_inst;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          // Halt wins over a misaligned target computed in the same cycle.
          if (halt_req) begin
            instret_d = instret_q + 64'd1;
            state_d   = StHalt;
          end else if (next_pc[1]) begin
            state_d = StTrap;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 64'd1;
            state_d   = StFetch;
          end
        end
      end
      StHalt, StTrap: begin
        state_d = state_q;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      instret_q <= 64'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  assign ifu.ifu_req_valid = (state_q == StFetch);
  assign ifu.ifu_req_addr  = pc_q;
  assign inst              = inst_q;
  assign inst_valid        = (state_q == StExec);
  assign pc                = pc_q;
  assign halted            = (state_q == StHalt);
  assign misalign_err      = (state_q == StTrap);
  assign instret           = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, branch/jalr targets,
// backpressure, trap/halt and reset abort, with hand-computed expectations.
module tb_pc_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [31:0]     inst;
  logic            inst_valid;
  logic            exec_done;
  logic            pc_a_src;
  logic            pc_b_src;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            halt_req;
  logic [XLEN-1:0] pc;
  logic            halted;
  logic            misalign_err;
  logic [63:0]     instret;

  int n_checks;
  int n_fail;

  pc_sequencer_if #(.XLEN(XLEN)) ifu_bus ();

  pc_sequencer #(
    .XLEN     (XLEN),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifu          (ifu_bus),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .exec_done    (exec_done),
    .pc_a_src     (pc_a_src),
    .pc_b_src     (pc_b_src),
    .imm          (imm),
    .rs1          (rs1),
    .halt_req     (halt_req),
    .pc           (pc),
    .halted       (halted),
    .misalign_err (misalign_err),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ifu_bus.ifu_req_ready = 1'b0;
    ifu_bus.ifu_rsp_valid = 1'b0;
    ifu_bus.ifu_rsp_inst  = 32'h0;
    exec_done = 1'b0;
    pc_a_src  = 1'b0;
    pc_b_src  = 1'b0;
    imm       = '0;
    rs1       = '0;
    halt_req  = 1'b0;
  endtask

  // Returns just after the negedge following reset release, state = FETCH.
  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 1", ifu_bus.ifu_req_valid);
    end
    n_checks++;
    if (ifu_bus.ifu_req_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_addr: got %h want 80000000", ifu_bus.ifu_req_addr);
    end
    n_checks++;
    if (pc !== 32'h8000_0000) begin
      n_fail++; $display("FAIL reset_pc: got %h want 80000000", pc);
    end
    n_checks++;
    if (inst !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_inst: got %h/%b want 0/0", inst, inst_valid);
    end
    n_checks++;
    if (instret !== 64'h0 || halted !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got instret=%0d halted=%b mis=%b want 0/0/0",
               instret, halted, misalign_err);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    ifu_bus.ifu_req_ready = 1'b1;
    ifu_bus.ifu_rsp_valid = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h8000_0000 + 32'(4 * i);
      exp_inst = 32'h0000_0013 | (32'(i) << 7);
      ifu_bus.ifu_rsp_inst = exp_inst;
      n_checks++;
      if (ifu_bus.ifu_req_valid !== 1'b1 || ifu_bus.ifu_req_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: got valid=%b addr=%h want 1/%h",
                 i, ifu_bus.ifu_req_valid, ifu_bus.ifu_req_addr, exp_addr);
      end
      step();
      n_checks++;
      if (ifu_bus.ifu_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_wait%0d: got req_valid=%b inst_valid=%b want 0/0",
                 i, ifu_bus.ifu_req_valid, inst_valid);
      end
      step();
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== exp_inst) begin
        n_fail++;
        $display("FAIL seq_exec%0d: got inst_valid=%b inst=%h want 1/%h",
                 i, inst_valid, inst, exp_inst);
      end
      step();
    end
    n_checks++;
    if (instret !== 64'd4 || pc !== 32'h8000_0010 || ifu_bus.ifu_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_end: got instret=%0d pc=%h valid=%b want 4/80000010/1",
               instret, pc, ifu_bus.ifu_req_valid);
    end
  endtask

  task automatic test_branch_imm();
    pc_a_src = 1'b1;
    pc_b_src = 1'b0;
    imm      = 32'hFFFF_FFF8;
    repeat (3) step();
    n_checks++;
    if (ifu_bus.ifu_req_addr !== 32'h8000_0008 || instret !== 64'd5) begin
      n_fail++;
      $display("FAIL branch_imm: got addr=%h instret=%0d want 80000008/5",
               ifu_bus.ifu_req_addr, instret);
    end
  endtask

  task automatic test_jalr();
    pc_a_src = 1'b1;
    pc_b_src = 1'b1;
    rs1      = 32'h8000_0101;
    imm      = 32'h0000_0004;
    repeat (3) step();
    n_checks++;
    if (pc !== 32'h8000_0104 || instret !== 64'd6) begin
      n_fail++; $display("FAIL jalr_imm: got pc=%h instret=%0d want 80000104/6", pc, instret);
    end
    pc_a_src = 1'b0;
    rs1      = 32'h8000_0201;
    imm      = 32'h0000_0100;
    repeat (3) step();
    n_checks++;
    if (pc !== 32'h8000_0204 || instret !== 64'd7) begin
      n_fail++; $display("FAIL jalr_4: got pc=%h instret=%0d want 80000204/7", pc, instret);
    end
    pc_b_src = 1'b0;
    imm      = '0;
    rs1      = '0;
  endtask

  task automatic test_backpressure();
    ifu_bus.ifu_req_ready = 1'b0;
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_inst  = 32'hDEAD_BEEF;
    exec_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ifu_bus.ifu_req_valid !== 1'b1 || ifu_bus.ifu_req_addr !== 32'h8000_0204) begin
        n_fail++;
        $display("FAIL bp_req_hold%0d: got valid=%b addr=%h want 1/80000204",
                 k, ifu_bus.ifu_req_valid, ifu_bus.ifu_req_addr);
      end
      if (k < 3) step();
    end
    ifu_bus.ifu_req_ready = 1'b1;
    ifu_bus.ifu_rsp_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_wait: got req_valid=%b inst_valid=%b want 0/0",
               ifu_bus.ifu_req_valid, inst_valid);
    end
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_inst  = 32'h0040_0093;
    step();
    ifu_bus.ifu_rsp_valid = 1'b0;
    ifu_bus.ifu_rsp_inst  = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      pc_a_src = 1'b1;
      pc_b_src = k[0];
      imm      = 32'(k * 3 + 1);
      rs1      = 32'h4000_0000 + 32'(k);
      n_checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0040_0093 || pc !== 32'h8000_0204) begin
        n_fail++;
        $display("FAIL bp_exec_hold%0d: got iv=%b inst=%h pc=%h want 1/00400093/80000204",
                 k, inst_valid, inst, pc);
      end
      step();
    end
    pc_a_src  = 1'b0;
    pc_b_src  = 1'b0;
    exec_done = 1'b1;
    step();
    n_checks++;
    if (pc !== 32'h8000_0208 || instret !== 64'd8 || ifu_bus.ifu_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_retire: got pc=%h instret=%0d valid=%b want 80000208/8/1",
               pc, instret, ifu_bus.ifu_req_valid);
    end
  endtask

  task automatic test_trap_halt();
    apply_reset();
    ifu_bus.ifu_req_ready = 1'b1;
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_inst  = 32'h0060_006F;
    exec_done = 1'b1;
    pc_a_src  = 1'b1;
    imm       = 32'h0000_0006;
    repeat (3) step();
    n_checks++;
    if (misalign_err !== 1'b1 || halted !== 1'b0 || pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL trap_state: got mis=%b halted=%b pc=%h want 1/0/80000000",
               misalign_err, halted, pc);
    end
    repeat (3) step();
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b0 || inst_valid !== 1'b0 || instret !== 64'd0 ||
        misalign_err !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_terminal: got valid=%b iv=%b instret=%0d mis=%b want 0/0/0/1",
               ifu_bus.ifu_req_valid, inst_valid, instret, misalign_err);
    end
    apply_reset();
    ifu_bus.ifu_req_ready = 1'b1;
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_inst  = 32'h0010_0073;
    exec_done = 1'b1;
    pc_a_src  = 1'b1;
    imm       = 32'h0000_0006;
    halt_req  = 1'b1;
    repeat (3) step();
    n_checks++;
    if (halted !== 1'b1 || misalign_err !== 1'b0 || pc !== 32'h8000_0000 ||
        instret !== 64'd1) begin
      n_fail++;
      $display("FAIL halt_state: got halted=%b mis=%b pc=%h instret=%0d want 1/0/80000000/1",
               halted, misalign_err, pc, instret);
    end
    repeat (3) step();
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_terminal: got valid=%b iv=%b halted=%b want 0/0/1",
               ifu_bus.ifu_req_valid, inst_valid, halted);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    ifu_bus.ifu_req_ready = 1'b1;
    step();
    ifu_bus.ifu_req_ready = 1'b0;
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_wait: got valid=%b want 0", ifu_bus.ifu_req_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifu_bus.ifu_req_valid !== 1'b1 || pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL abort_async: got valid=%b pc=%h want 1/80000000",
               ifu_bus.ifu_req_valid, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_inst  = 32'hCAFE_F00D;
    step();
    step();
    n_checks++;
    if (inst !== 32'h0 || inst_valid !== 1'b0 || ifu_bus.ifu_req_valid !== 1'b1 ||
        ifu_bus.ifu_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL abort_rsp_ignored: got inst=%h iv=%b valid=%b addr=%h want 0/0/1/80000000",
               inst, inst_valid, ifu_bus.ifu_req_valid, ifu_bus.ifu_req_addr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_idle();
    test_reset();
    test_sequential();
    test_branch_imm();
    test_jalr();
    test_backpressure();
    test_trap_halt();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
